boid_pixel_reader: RTL

- Read-side counterpart of the boid display memory writer.
- Converts the VGA controller's pixel coordinates into 1-bit display-RAM read addresses and turns the returned bit into 12-bit RGB.
- Delays hSync/vSync/active so they stay aligned with the RAM read latency.
- Owns the double-buffer bank select and swaps banks only at frame end, through a req/ack handshake with the boid writer, so boids never tear mid-frame.

---
 rtl/boid_pixel_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/boid_pixel_reader.sv
// boid_pixel_reader
//   Read side of the boid double-buffered display RAM. Maps VGA pixel
//   coordinates to a 1-bit RAM read address. Turns the returned bit into
//   12-bit RGB. Delays hsync/vsync so they stay aligned with the RAM read.
//   Owns the displayed bank and swaps it only at frame end, using a
//   req/ack handshake with the boid writer.
//
//   clk_i, rst_ni        system clock, async active-low reset
//   pix_en_i             pixel tick; the pixel pipeline advances only when high
//   x_i, y_i, active_i   pixel coordinate and visible-area flag from VGA timing
//   hsync_i, vsync_i     active-low syncs from VGA timing
//   rd_addr_o, rd_bank_o display-RAM read address and displayed bank
//   rd_data_i            boid bit, valid RAM_LATENCY ticks after rd_addr_o
//   swap_req_i           level request from writer (back bank complete)
//   swap_ack_o           one-clock pulse when the bank has been swapped
//   frame_end_o          one-clock pulse after the last visible pixel is sampled
//   rgb_o                {R,G,B} 4 bits each
//   hsync_o, vsync_o     syncs delayed by 1+RAM_LATENCY pixel ticks
//
// Bank FSM
//   state     | meaning
//   S_IDLE    | no swap outstanding; accepts registered swap_req once hold-off expires
//   S_PENDING | swap requested; waiting for frame_end, cancelled if swap_req drops
//   S_SWAP    | single clock: swap_ack high, rd_bank toggles on exit
module boid_pixel_reader #(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          ADDR_WIDTH  = 19,
  parameter int          RAM_LATENCY = 1,
  parameter logic [11:0] BOID_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pix_en_i,
  input  logic [9:0]            x_i,
  input  logic [8:0]            y_i,
  input  logic                  active_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_bank_o,
  input  logic                  rd_data_i,
  input  logic                  swap_req_i,
  output logic                  swap_ack_o,
  output logic                  frame_end_o,
  output logic [11:0]           rgb_o,
  output logic                  hsync_o,
  output logic                  vsync_o
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_SWAP} state_t;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  // Delay-line entry: {blank, hsync, vsync}. Reset value keeps syncs idle-high.
  localparam logic [2:0] DL_RESET = 3'b011;

  logic                  in_range;
  addr_t                 addr_full;
  addr_t                 rd_addr_q;
  logic [2:0]            dl_q [RAM_LATENCY];
  logic [2:0]            dl_last;
  logic [11:0]           rgb_q;
  logic                  hsync_q, vsync_q;
  logic                  frame_end_q;
  logic                  req_q;
  state_t                state_q, state_d;
  logic                  bank_q, bank_d;
  logic [1:0]            holdoff_q, holdoff_d;

  assign in_range  = active_i && (x_i < 10'(H_ACTIVE)) && (y_i < 9'(V_ACTIVE));
  // 640*y = 512*y + 128*y, done at full address width.
  assign addr_full = (addr_t'(y_i) << 9) + (addr_t'(y_i) << 7) + addr_t'(x_i);
  assign dl_last   = dl_q[RAM_LATENCY-1];

  // Pixel pipeline. Stage 0 issues the address. dl_q carries blank/syncs
  // alongside the RAM read. The final stage meets rd_data_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) dl_q[i] <= DL_RESET;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_en_i) begin
      rd_addr_q <= in_range ? addr_full : '0;
      dl_q[0]   <= {~in_range, hsync_i, vsync_i};
      for (int i = 1; i < RAM_LATENCY; i++) dl_q[i] <= dl_q[i-1];
      rgb_q   <= (dl_last[2] || !rd_data_i) ? BG_COLOR : BOID_COLOR;
      hsync_q <= dl_last[1];
      vsync_q <= dl_last[0];
    end
  end

  // frame_end and the request sampler run at clock rate, not pixel rate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_end_q <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      frame_end_q <= pix_en_i && active_i && (x_i == X_LAST) && (y_i == Y_LAST);
      req_q       <= swap_req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      bank_q    <= 1'b0;
      holdoff_q <= '0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      holdoff_q <= holdoff_d;
    end
  end

  // holdoff_q gives the writer two clocks after ack to drop its request
  // before a still-high request counts as a new one.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    holdoff_d = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
    case (state_q)
      S_IDLE:    if (req_q && (holdoff_q == 2'd0)) state_d = S_PENDING;
      S_PENDING: begin
        if (!req_q)           state_d = S_IDLE;
        else if (frame_end_q) state_d = S_SWAP;
      end
      S_SWAP: begin
        state_d   = S_IDLE;
        bank_d    = ~bank_q;
        holdoff_d = 2'd2;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    swap_ack_o = (state_q == S_SWAP);
  end

  assign rd_addr_o   = rd_addr_q;
  assign rd_bank_o   = bank_q;
  assign frame_end_o = frame_end_q;
  assign rgb_o       = rgb_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;

endmodule
